// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LSU memory arbiter, one outstanding transaction, LSU burst starvation guard.
// Define MEM_ARBITER_PERF_CNT_EN to enable the per-requester grant counters.
module mem_arbiter #(
  parameter int XLEN          = 32,
  parameter int LSU_MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic [3:0]      lsu_be_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_ready_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [31:0]     if_grant_cnt_o,
  output logic [31:0]     lsu_grant_cnt_o
);
  localparam int CW = ($clog2(LSU_MAX_BURST + 1) > 3) ? $clog2(LSU_MAX_BURST + 1) : 3;
  localparam logic [CW-1:0] BURST_MAX = CW'(LSU_MAX_BURST);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LSU} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] burst_cnt;
  logic          sel_if;
  logic          lsu_we_q;

  // IF only overtakes a pending LSU once the LSU has had its full burst
  assign sel_if = if_req_i & (~lsu_req_i | (burst_cnt == BURST_MAX));

  always_comb begin
    state_nxt   = state;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'h0;
    if_gnt_o    = 1'b0;
    lsu_gnt_o   = 1'b0;
    case (state)
      IDLE: begin
        mem_req_o = if_req_i | lsu_req_i;
        if (sel_if) begin
          mem_addr_o = if_addr_i;
          mem_be_o   = 4'hF;
          if_gnt_o   = mem_ready_i;
          if (mem_ready_i) state_nxt = WAIT_IF;
        end else if (lsu_req_i) begin
          mem_we_o    = lsu_we_i;
          mem_addr_o  = lsu_addr_i;
          mem_wdata_o = lsu_wdata_i;
          mem_be_o    = lsu_be_i;
          lsu_gnt_o   = mem_ready_i;
          if (mem_ready_i) state_nxt = WAIT_LSU;
        end
      end
      WAIT_IF:  if (mem_rvalid_i) state_nxt = IDLE;
      WAIT_LSU: if (mem_rvalid_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      lsu_we_q     <= 1'b0;
      if_rvalid_o  <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      if_rdata_o   <= '0;
      lsu_rdata_o  <= '0;
    end else begin
      state        <= state_nxt;
      if_rvalid_o  <= (state == WAIT_IF) & mem_rvalid_i;
      lsu_rvalid_o <= (state == WAIT_LSU) & mem_rvalid_i;
      if ((state == WAIT_IF) && mem_rvalid_i) if_rdata_o <= mem_rdata_i;
      // store acks leave the last load data visible
      if ((state == WAIT_LSU) && mem_rvalid_i && !lsu_we_q) lsu_rdata_o <= mem_rdata_i;
      if (lsu_gnt_o) lsu_we_q <= lsu_we_i;
      if (!if_req_i || if_gnt_o) burst_cnt <= '0;
      else if (lsu_gnt_o && (burst_cnt != BURST_MAX)) burst_cnt <= burst_cnt + CW'(1);
    end
  end

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [31:0] if_cnt, lsu_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_cnt  <= '0;
      lsu_cnt <= '0;
    end else begin
      if (if_gnt_o)  if_cnt  <= if_cnt + 32'd1;
      if (lsu_gnt_o) lsu_cnt <= lsu_cnt + 32'd1;
    end
  end

  assign if_grant_cnt_o  = if_cnt;
  assign lsu_grant_cnt_o = lsu_cnt;
`else
  assign if_grant_cnt_o  = '0;
  assign lsu_grant_cnt_o = '0;
`endif
endmodule
